centroid_updater: RTL and testbench

Sequential centroid-update stage of the k-means datapath. Consumes the per-cluster coordinate sums (64-bit) and point counts (32-bit) produced by the accumulation stage and computes each new centroid coordinate with a shared multi-cycle divider instead of 2**n·d parallel combinational dividers. Also reports whether the iteration has converged against the previous centroids, for use by the top-level iteration controller.

---
 rtl/kmeans_pkg.sv | 19 +
 rtl/seq_divider.sv | 66 ++++++
 rtl/centroid_updater.sv | 139 +++++++++++++
 tb/tb_centroid_updater.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/kmeans_pkg.sv
// Shared k-means datapath types: coordinate/sum/count widths, the centroid
// updater FSM encoding and the element-count helper.
package kmeans_pkg;
  typedef logic [31:0] coord_t;
  typedef logic [63:0] sum_t;
  typedef logic [31:0] count_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DIV   = 3'd2,
    S_STORE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic int num_elems(input int n, input int d);
    return (2 ** n) * d;
  endfunction
endpackage

// File: rtl/seq_divider.sv
// 64/32 restoring radix-2 divider, one quotient bit per cycle, MSB first.
// Caller guarantees dividend[63:32] < divisor, so the quotient fits 32 bits.
module seq_divider
  import kmeans_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   start_i,
  input  sum_t   dividend_i,
  input  count_t divisor_i,
  output logic   last_o,
  output coord_t quotient_o
);
  logic        active_q, active_d;
  logic [4:0]  cnt_q, cnt_d;
  count_t      rem_q, rem_d;
  coord_t      quo_q, quo_d;
  count_t      dvs_q, dvs_d;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        fits;

  // The low dividend half shifts out of quo_q while quotient bits shift in.
  assign shifted = {rem_q, quo_q[31]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign fits    = (shifted >= {1'b0, dvs_q});

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    if (start_i) begin
      active_d = 1'b1;
      cnt_d    = '0;
      rem_d    = dividend_i[63:32];
      quo_d    = dividend_i[31:0];
      dvs_d    = divisor_i;
    end else if (active_q) begin
      rem_d = fits ? diff[31:0] : shifted[31:0];
      quo_d = {quo_q[30:0], fits};
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd31) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
    end
  end

  assign last_o     = active_q && (cnt_q == 5'd31);
  assign quotient_o = quo_q;
endmodule

// File: rtl/centroid_updater.sv
// Sequential centroid update: walks every (cluster, coordinate) element,
// divides sum by count on a shared divider and tracks the max centroid shift.
module centroid_updater
  import kmeans_pkg::*;
#(
  parameter int     N   = 8,
  parameter int     D   = 2,
  parameter coord_t TOL = 32'd0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  sum_t   [2**N-1:0][D-1:0]       accu,
  input  count_t [2**N-1:0]              incr,
  input  coord_t [2**N-1:0][D-1:0]       centroids,
  output logic                           busy,
  output logic                           done,
  output logic                           converged,
  output coord_t [2**N-1:0][D-1:0]       new_centroids,
  output state_t                         dbg_state
);
  localparam int IW = (N > 0) ? N : 1;
  localparam int JW = (D > 1) ? $clog2(D) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(2**N - 1);
  localparam logic [JW-1:0] J_LAST = JW'(D - 1);

  // Handshake: start is a one-cycle request honoured only in IDLE; inputs stay
  // stable while busy; done pulses exactly once per completed pass.
  state_t                     state_q, state_d;
  logic [IW-1:0]              i_q, i_d;
  logic [JW-1:0]              j_q, j_d;
  coord_t                     maxd_q, maxd_d;
  logic                       conv_q, conv_d;
  logic                       zero_q, zero_d;
  coord_t [2**N-1:0][D-1:0]   new_q, new_d;

  logic   div_start;
  logic   div_last;
  coord_t div_quot;
  coord_t old_val;
  coord_t store_val;
  coord_t delta;
  coord_t max_next;
  logic   elem_last;
  logic   cnt_zero;

  seq_divider u_div (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (div_start),
    .dividend_i (accu[i_q][j_q]),
    .divisor_i  (incr[i_q]),
    .last_o     (div_last),
    .quotient_o (div_quot)
  );

  assign cnt_zero  = (incr[i_q] == '0);
  assign elem_last = (i_q == I_LAST) && (j_q == J_LAST);
  assign old_val   = centroids[i_q][j_q];
  // An empty cluster keeps its old centroid.
  assign store_val = zero_q ? old_val : div_quot;
  assign delta     = (store_val >= old_val) ? (store_val - old_val) : (old_val - store_val);
  assign max_next  = (delta > maxd_q) ? delta : maxd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  state_d = cnt_zero ? S_STORE : S_DIV;
      S_DIV:   if (div_last) state_d = S_STORE;
      S_STORE: state_d = elem_last ? S_DONE : S_LOAD;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == S_LOAD) || (state_q == S_DIV) || (state_q == S_STORE);
    done      = (state_q == S_DONE);
    div_start = (state_q == S_LOAD) && !cnt_zero;
  end

  always_comb begin
    i_d    = i_q;
    j_d    = j_q;
    maxd_d = maxd_q;
    conv_d = conv_q;
    zero_d = zero_q;
    new_d  = new_q;
    case (state_q)
      S_IDLE: if (start) begin
        i_d    = '0;
        j_d    = '0;
        maxd_d = '0;
      end
      S_LOAD: zero_d = cnt_zero;
      S_STORE: begin
        new_d[i_q][j_q] = store_val;
        maxd_d          = max_next;
        if (elem_last) begin
          conv_d = (max_next <= TOL);
        end else if (j_q == J_LAST) begin
          j_d = '0;
          i_d = i_q + IW'(1);
        end else begin
          j_d = j_q + JW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q    <= '0;
      j_q    <= '0;
      maxd_q <= '0;
      conv_q <= 1'b0;
      zero_q <= 1'b0;
      new_q  <= '0;
    end else begin
      i_q    <= i_d;
      j_q    <= j_d;
      maxd_q <= maxd_d;
      conv_q <= conv_d;
      zero_q <= zero_d;
      new_q  <= new_d;
    end
  end

  assign converged     = conv_q;
  assign new_centroids = new_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_centroid_updater.sv
// Bench for centroid_updater (n=1, d=2): two instances with TOL=0 and TOL=1
// share stimulus; results are compared against a plain-arithmetic model.
module tb_centroid_updater;
  import kmeans_pkg::*;

  localparam int NC    = 2;
  localparam int ND    = 2;
  localparam int LIMIT = 1000;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [NC-1:0][ND-1:0][63:0] accu;
  logic [NC-1:0][31:0]         incr;
  logic [NC-1:0][ND-1:0][31:0] centroids;
  logic busy_a, done_a, conv_a, busy_b, done_b, conv_b;
  logic [NC-1:0][ND-1:0][31:0] new_a, new_b;
  state_t state_a, state_b;

  logic [63:0] sum_m [NC][ND];
  logic [31:0] cnt_m [NC];
  logic [31:0] old_m [NC][ND];
  logic [31:0] exp_q [$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  centroid_updater #(.N(1), .D(2), .TOL(32'd0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .accu(accu), .incr(incr),
    .centroids(centroids), .busy(busy_a), .done(done_a), .converged(conv_a),
    .new_centroids(new_a), .dbg_state(state_a)
  );

  centroid_updater #(.N(1), .D(2), .TOL(32'd1)) dut_b (
    .clk(clk), .rst(rst), .start(start), .accu(accu), .incr(incr),
    .centroids(centroids), .busy(busy_b), .done(done_b), .converged(conv_b),
    .new_centroids(new_b), .dbg_state(state_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < NC; i++) begin
      incr[i] = cnt_m[i];
      for (int j = 0; j < ND; j++) begin
        accu[i][j]      = sum_m[i][j];
        centroids[i][j] = old_m[i][j];
      end
    end
  endtask

  // Random element: quotient either near the old centroid or anywhere.
  task automatic randomize_cfg();
    logic [31:0] q;
    logic [31:0] r;
    for (int i = 0; i < NC; i++) begin
      case ($urandom_range(0, 3))
        0:       cnt_m[i] = 32'd0;
        1:       cnt_m[i] = $urandom_range(1, 16);
        default: cnt_m[i] = $urandom | 32'd1;
      endcase
      for (int j = 0; j < ND; j++) begin
        old_m[i][j] = $urandom;
        if ($urandom_range(0, 1) == 1) q = old_m[i][j] + $urandom_range(0, 2) - 32'd1;
        else                           q = $urandom;
        r = (cnt_m[i] == 0) ? 32'd0 : ($urandom % cnt_m[i]);
        sum_m[i][j] = (cnt_m[i] == 0) ? {$urandom, $urandom}
                                      : (64'(q) * 64'(cnt_m[i]) + 64'(r));
      end
    end
  endtask

  task automatic run_pass(input string name, input int ignore_at);
    int          exp_lat;
    int          lat;
    int          busy_cnt;
    int          extra_done;
    logic [31:0] q;
    logic [31:0] d;
    logic [31:0] maxd;
    logic [31:0] e;
    exp_lat = 0;
    maxd    = 0;
    for (int i = 0; i < NC; i++)
      for (int j = 0; j < ND; j++) begin
        if (cnt_m[i] == 0) begin
          q = old_m[i][j];
          exp_lat += 2;
        end else begin
          q = 32'(sum_m[i][j] / {32'd0, cnt_m[i]});
          exp_lat += 34;
        end
        d = (q >= old_m[i][j]) ? q - old_m[i][j] : old_m[i][j] - q;
        if (d > maxd) maxd = d;
        exp_q.push_back(q);
      end

    apply();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    while (!done_a && lat < LIMIT) begin
      if (busy_a) busy_cnt++;
      start = (lat == ignore_at) ? 1'b1 : 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({name, " latency"}, lat, exp_lat);
    check({name, " busy_cycles"}, busy_cnt, exp_lat);
    check({name, " busy_at_done"}, busy_a, 1'b0);
    check({name, " done_b"}, done_b, 1'b1);
    check({name, " conv_tol0"}, conv_a, (maxd <= 32'd0));
    check({name, " conv_tol1"}, conv_b, (maxd <= 32'd1));
    for (int i = 0; i < NC; i++)
      for (int j = 0; j < ND; j++) begin
        e = exp_q.pop_front();
        check($sformatf("%s new_a[%0d][%0d]", name, i, j), new_a[i][j], e);
        check($sformatf("%s new_b[%0d][%0d]", name, i, j), new_b[i][j], e);
      end
    extra_done = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done_a) extra_done++;
    end
    check({name, " single_done"}, extra_done, 0);
    check({name, " idle_after"}, state_a, S_IDLE);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    accu  = '0;
    incr  = '0;
    centroids = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset busy", busy_a, 1'b0);
    check("reset done", done_a, 1'b0);
    check("reset converged", conv_a, 1'b0);
    check("reset new_centroids", new_a, '0);
    check("reset state", state_a, S_IDLE);

    sum_m[0][0] = 64'd10; sum_m[0][1] = 64'd20; sum_m[1][0] = 64'd9; sum_m[1][1] = 64'd7;
    cnt_m[0] = 32'd2; cnt_m[1] = 32'd3;
    old_m[0][0] = 32'd0; old_m[0][1] = 32'd0; old_m[1][0] = 32'd3; old_m[1][1] = 32'd2;
    check("K constant", num_elems(1, 2), NC * ND);
    run_pass("basic", -1);

    cnt_m[1] = 32'd0; old_m[1][0] = 32'd77; old_m[1][1] = 32'd88;
    run_pass("empty_cluster", -1);

    sum_m[0][0] = 64'hFFFF_FFFE_0000_0002; sum_m[0][1] = 64'd0; cnt_m[0] = 32'hFFFF_FFFF;
    sum_m[1][0] = 64'd7; sum_m[1][1] = 64'd1; cnt_m[1] = 32'd2;
    old_m[0][0] = 32'd0; old_m[0][1] = 32'd5; old_m[1][0] = 32'd0; old_m[1][1] = 32'd0;
    run_pass("wide_trunc", -1);

    cnt_m[0] = 32'd4; cnt_m[1] = 32'd5;
    sum_m[0][0] = 64'd401; sum_m[0][1] = 64'd801; sum_m[1][0] = 64'd1501; sum_m[1][1] = 64'd2001;
    old_m[0][0] = 32'd101; old_m[0][1] = 32'd199; old_m[1][0] = 32'd301; old_m[1][1] = 32'd399;
    run_pass("tol_pm1", -1);

    cnt_m[0] = 32'd1; sum_m[0][0] = 64'h0000_0000_DEAD_BEEF; sum_m[0][1] = 64'd42;
    run_pass("start_while_busy", 5);

    for (int t = 0; t < 10; t++) begin
      randomize_cfg();
      run_pass($sformatf("rand%0d", t), (t % 2 == 0) ? int'($urandom_range(1, 60)) : -1);
    end

    cnt_m[0] = 32'd3; cnt_m[1] = 32'd6;
    sum_m[0][0] = 64'd30; sum_m[0][1] = 64'd33; sum_m[1][0] = 64'd60; sum_m[1][1] = 64'd66;
    apply();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (68 + 15) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset busy", busy_a, 1'b0);
    check("midreset done", done_a, 1'b0);
    check("midreset new_centroids", new_a, '0);
    check("midreset state", state_a, S_IDLE);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_pass("after_reset", -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
